// File: rtl/tdc_stream_scheduler.sv
// tdc_stream_scheduler: collects per-pixel TDC hits into a ping-pong buffer
// and replays each closed acquisition as a fixed-length wrEn/data word stream
// (pixel-major, slot-minor, empty slots padded with all-ones).
//
// Handshake: a hit transfers on a rising clk edge where tdc_valid and
// tdc_ready are both high; acq_end is honoured only on an edge where
// acq_ready is high, otherwise it is dropped and overrun is set. The output
// stream has no backpressure: every cycle with wrEn high carries one word.
module tdc_stream_scheduler #(
  parameter int NP        = 12,
  parameter int DATA_NUM  = 2,
  parameter int PIXEL_NUM = 4,
  parameter int ACQ_NUM   = 8,
  parameter int FRAME_GAP = 4,
  parameter int PW        = $clog2(PIXEL_NUM)
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       tdc_valid,
  output logic                       tdc_ready,
  input  logic [PW-1:0]              tdc_pixel,
  input  logic [NP-1:0]              tdc_time,
  input  logic                       acq_end,
  output logic                       acq_ready,
  output logic                       wrEn,
  output logic [NP-1:0]              data,
  output logic                       frame_done,
  output logic [$clog2(ACQ_NUM)-1:0] acq_cnt,
  output logic [15:0]                drop_cnt,
  output logic                       overrun,
  output logic [1:0]                 dbg_state
);

  localparam int SW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int CW = $clog2(DATA_NUM + 1);
  localparam int AW = $clog2(ACQ_NUM);
  localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_GAP = 2'd2} state_t;

  // Bank storage and bookkeeping
  logic [NP-1:0] mem [2][PIXEL_NUM][DATA_NUM];
  logic [CW-1:0] cnt [2][PIXEL_NUM];
  logic [1:0]    full;
  logic          col_bank;   // bank receiving hits (or just closed when !col_open)
  logic          col_open;   // a collect bank is accepting hits
  logic          other_bank;

  // Streamer state
  state_t        state, state_d;
  logic          str_bank, str_bank_d;
  logic [PW-1:0] pix, pix_d;
  logic [SW-1:0] slot, slot_d;
  logic [GW-1:0] gap, gap_d;
  logic          wr_en_d, frame_done_d;
  logic [NP-1:0] data_d;
  logic [AW-1:0] acq_cnt_d;
  logic          last_slot, last_word, slot_done, bank_done;
  logic          next_bank;

  // Hit qualification
  logic          hit_fire, hit_ok, in_range;
  logic [CW-1:0] hit_cnt;

  assign other_bank = ~col_bank;
  assign tdc_ready  = col_open;
  assign acq_ready  = col_open;
  assign dbg_state  = state;

  assign in_range = ({1'b0, tdc_pixel} < (PW+1)'(PIXEL_NUM));
  assign hit_cnt  = cnt[col_bank][tdc_pixel];
  assign hit_fire = tdc_valid && col_open;
  assign hit_ok   = hit_fire && in_range && !(&tdc_time) && (hit_cnt < CW'(DATA_NUM));

  // The older full bank always streams first: that is the non-collect bank.
  assign next_bank = full[other_bank] ? other_bank : col_bank;

  assign last_slot = (slot == SW'(DATA_NUM - 1));
  assign last_word = last_slot && (pix == PW'(PIXEL_NUM - 1));
  assign slot_done = (state == S_STREAM) && last_slot;
  assign bank_done = (state == S_STREAM) && last_word;

  // Hit payload write; contents are qualified by cnt, so no reset needed
  always_ff @(posedge clk) begin
    if (hit_ok) mem[col_bank][tdc_pixel][SW'(hit_cnt)] <= tdc_time;
  end

  // Bank ownership, hit counts, drop counter and overrun flag
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      col_bank <= 1'b0;
      col_open <= 1'b1;
      full     <= '0;
      drop_cnt <= '0;
      overrun  <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int p = 0; p < PIXEL_NUM; p++)
          cnt[b][p] <= '0;
    end else begin
      if (hit_ok)
        cnt[col_bank][tdc_pixel] <= hit_cnt + 1'b1;
      else if (hit_fire && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 1'b1;
      if (slot_done) cnt[str_bank][pix] <= '0;
      if (bank_done) full[str_bank] <= 1'b0;
      if (acq_end) begin
        if (col_open) begin
          full[col_bank] <= 1'b1;
          if (!full[other_bank]) col_bank <= other_bank;
          else                   col_open <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (!col_open && !full[other_bank]) begin
        // Streaming bank has drained: it becomes the collect bank.
        col_bank <= other_bank;
        col_open <= 1'b1;
      end
    end
  end

  // Streamer state and registered stream outputs
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= S_IDLE;
      str_bank   <= 1'b0;
      pix        <= '0;
      slot       <= '0;
      gap        <= '0;
      wrEn       <= 1'b0;
      data       <= '1;
      frame_done <= 1'b0;
      acq_cnt    <= '0;
    end else begin
      state      <= state_d;
      str_bank   <= str_bank_d;
      pix        <= pix_d;
      slot       <= slot_d;
      gap        <= gap_d;
      wrEn       <= wr_en_d;
      data       <= data_d;
      frame_done <= frame_done_d;
      acq_cnt    <= acq_cnt_d;
    end
  end

  // Streamer next-state and next-output logic
  always_comb begin
    state_d      = state;
    str_bank_d   = str_bank;
    pix_d        = pix;
    slot_d       = slot;
    gap_d        = gap;
    wr_en_d      = 1'b0;
    data_d       = '1;
    frame_done_d = 1'b0;
    acq_cnt_d    = acq_cnt;
    case (state)
      S_IDLE: begin
        if (full[next_bank]) begin
          state_d    = S_STREAM;
          str_bank_d = next_bank;
          pix_d      = '0;
          slot_d     = '0;
        end
      end
      S_STREAM: begin
        wr_en_d = 1'b1;
        data_d  = (CW'(slot) < cnt[str_bank][pix]) ? mem[str_bank][pix][slot] : '1;
        if (last_slot) begin
          slot_d = '0;
          pix_d  = pix + 1'b1;
        end else begin
          slot_d = slot + 1'b1;
        end
        if (last_word) begin
          pix_d = '0;
          if (acq_cnt == AW'(ACQ_NUM - 1)) begin
            frame_done_d = 1'b1;
            acq_cnt_d    = '0;
            state_d      = S_GAP;
            gap_d        = '0;
          end else begin
            acq_cnt_d = acq_cnt + 1'b1;
            if (full[~str_bank]) str_bank_d = ~str_bank;
            else                 state_d    = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap == GW'(FRAME_GAP - 1)) state_d = S_IDLE;
        else                           gap_d   = gap + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
